// File: rtl/jamma_joy_scanner.sv
// Time-multiplexes the shared JAMMA joystick bus between two players, debounces each
// player's byte and merges the keyboard joystick into player 1 (all active-low).
module jamma_joy_scanner #(
  parameter int SETTLE_CYCLES    = 4,
  parameter int DEBOUNCE_SAMPLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] jjoy,
  input  logic [5:0] kbd_joy,
  output logic       jselect,
  output logic [7:0] joystick1,
  output logic [7:0] joystick2,
  output logic       scan_done
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] CNT_MAX     = DW'(DEBOUNCE_SAMPLES - 1);

  typedef enum logic [1:0] {
    SEL1_SETTLE,
    SEL1_SAMPLE,
    SEL2_SETTLE,
    SEL2_SAMPLE
  } state_t;

  state_t        state;
  logic [SW-1:0] settle_cnt;
  logic [7:0]    prev1, prev2, deb1, deb2;
  logic [DW-1:0] cnt1, cnt2, cnt1_next, cnt2_next;
  logic          same1, same2, take1, take2;

  // Both players' next debounce values are computed from the live bus; only the
  // one whose SAMPLE state is active gets committed.
  always_comb begin
    same1     = (jjoy == prev1);
    same2     = (jjoy == prev2);
    cnt1_next = '0;
    cnt2_next = '0;
    if (same1) cnt1_next = (cnt1 == CNT_MAX) ? cnt1 : cnt1 + 1'b1;
    if (same2) cnt2_next = (cnt2 == CNT_MAX) ? cnt2 : cnt2 + 1'b1;
    take1 = (DEBOUNCE_SAMPLES == 1) || (same1 && (int'(cnt1) + 1 >= DEBOUNCE_SAMPLES - 1));
    take2 = (DEBOUNCE_SAMPLES == 1) || (same2 && (int'(cnt2) + 1 >= DEBOUNCE_SAMPLES - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SEL1_SETTLE;
      settle_cnt <= '0;
      jselect    <= 1'b0;
      scan_done  <= 1'b0;
      prev1      <= 8'hFF;
      prev2      <= 8'hFF;
      deb1       <= 8'hFF;
      deb2       <= 8'hFF;
      cnt1       <= '0;
      cnt2       <= '0;
      joystick1  <= 8'hFF;
      joystick2  <= 8'hFF;
    end else begin
      scan_done <= 1'b0;
      joystick1 <= deb1 & {2'b11, kbd_joy};
      joystick2 <= deb2;
      case (state)
        SEL1_SETTLE, SEL2_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= (state == SEL1_SETTLE) ? SEL1_SAMPLE : SEL2_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        SEL1_SAMPLE: begin
          prev1   <= jjoy;
          cnt1    <= cnt1_next;
          if (take1) deb1 <= jjoy;
          jselect <= 1'b1;
          state   <= SEL2_SETTLE;
        end
        SEL2_SAMPLE: begin
          prev2     <= jjoy;
          cnt2      <= cnt2_next;
          if (take2) deb2 <= jjoy;
          jselect   <= 1'b0;
          scan_done <= 1'b1;
          state     <= SEL1_SETTLE;
        end
        default: state <= SEL1_SETTLE;
      endcase
    end
  end

endmodule
